ff_inverse: RTL and testbench
=============================

// Module: ff_inverse
// PURPOSE
//   Sequential GF(2^NUM_BITS) multiplicative inverter (AES S-box front end, decrypt key path).
//   Computes result = operand^(2^NUM_BITS - 2) mod POLY by left-to-right square-and-multiply.
//   Contains one combinational reduce-mod-POLY multiplier, reused every cycle.
//   inverse(0) = 0 by construction. No reset-free state.
// PARAMETERS
//   NUM_BITS  8        field width; legal range 3..8
//   POLY      9'h11B   irreducible reduction polynomial, NUM_BITS+1 bits, MSB must be 1
// PORTS
//   clk      in   1         system clock, rising edge
//   n_rst    in   1         asynchronous active-low reset
//   start    in   1         request; sampled only in IDLE
//   operand  in   NUM_BITS  value to invert; captured on the accepted start edge
//   busy     out  1         high in every state except IDLE
//   done     out  1         one-cycle completion pulse
//   result   out  NUM_BITS  inverse; updated only on DONE entry, held until the next completion
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, result=0; a_reg, acc, cnt cleared.
//   The exponent 2^N-2 has bits N-1..1 = 1 and bit 0 = 0. acc is preloaded with a, covering bit N-1.
//   FSM (one transition per rising edge):
//     IDLE : start=1 -> a_reg<=operand, acc<=operand, cnt<=N-2, go SQR. start=0 -> stay.
//     SQR  : acc<=gf_mul(acc,acc).
//            If cnt!=0 -> go MUL (the exponent bit is 1).
//            If cnt==0 -> go DONE (bit 0 is 0) and load result<=gf_mul(acc,acc).
//     MUL  : acc<=gf_mul(acc,a_reg), cnt<=cnt-1, go SQR.
//     DONE : done=1 for this state only; go IDLE unconditionally.
//   gf_mul: carry-less product of width 2N-1, then reduced mod POLY to N bits.
//     Purely combinational; settles within one clock.
//   Op count: N-1 SQR + N-2 MUL = 2N-3 (13 for N=8).
//   Latency, start high at edge E:
//     - busy rises after E.
//     - DONE is entered at edge E+2N-3.
//     - done is high for exactly one period, from E+2N-3 to E+2N-2.
//     - busy falls at E+2N-2.
//     - A new start is accepted at E+2N-2 at the earliest.
//   done and busy are both registered (state-decoded) outputs. done=1 implies busy=1.
//   start while busy (SQR/MUL/DONE): ignored, no queuing. operand changes after capture: no effect.
//   result is stable while busy. It changes only at the DONE-entry edge, even if the value is equal.
//   operand=0: all products are 0 -> result=0, same latency.
//   n_rst low mid-operation: immediate return to IDLE and all outputs 0. The partial result is discarded.
//   No X propagation. Unused state encodings recover to IDLE.
// TESTING
//   1. Reset with start=0: busy=0, done=0, result=0. Hold 5 cycles -> no change.
//   2. start=1 for one edge, operand=8'h53.
//      -> busy high 14 cycles, done pulses once at cycle 14, result=8'hCA.
//      Then operand=8'hCA -> result=8'h53.
//   3. Boundary values:
//      8'h01 -> 8'h01; 8'h02 -> 8'h8D; 8'h00 -> 8'h00; 8'hFF -> 8'h1C.
//      Each with the identical 14-cycle latency.
//   4. Sweep all 256 operands back-to-back, restarting on the first idle edge.
//      -> gf_mul(operand,result)==1 for every nonzero operand; exactly 256 done pulses.
//   5. Start 8'h53. Pulse start with 8'h02 at cycles 3 and 13 (while busy).
//      -> both pulses ignored; result=8'hCA; result unchanged before done.
//   6. Start 8'h53, then assert n_rst low at cycle 6.
//      -> busy=0, done=0, result=0 immediately, no done pulse.
//      After release, start 8'h02 -> result=8'h8D.

Source files
------------

// File: rtl/ff_inverse.sv
// GF(2^NUM_BITS) multiplicative inverter: operand^(2^N-2) by square-and-multiply.
// One shared reduce-mod-POLY multiplier, one field operation per cycle.
module ff_inverse #(
    parameter int               NUM_BITS = 8,
    parameter logic [NUM_BITS:0] POLY    = 9'h11B
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] operand,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] result
);

    localparam int N  = NUM_BITS;
    localparam int CW = $clog2(NUM_BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state, state_nx;
    logic [N-1:0]   a_reg, a_nx;
    logic [N-1:0]   acc, acc_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [N-1:0]   result_nx;
    logic [N-1:0]   mul_b;
    logic [N-1:0]   prod;

    function automatic logic [N-1:0] gf_mul(
        input logic [N-1:0] x,
        input logic [N-1:0] y
    );
        logic [2*N-2:0] p;
        p = '0;
        for (int i = 0; i < N; i++) begin
            if (y[i]) p = p ^ ({{(N-1){1'b0}}, x} << i);
        end
        for (int i = 2*N-2; i >= N; i--) begin
            if (p[i]) p = p ^ ({{(N-2){1'b0}}, POLY} << (i - N));
        end
        return p[N-1:0];
    endfunction

    // Squaring in SQR, multiply by the captured operand in MUL.
    assign mul_b = (state == MUL) ? a_reg : acc;
    assign prod  = gf_mul(acc, mul_b);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            a_reg  <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            state  <= state_nx;
            a_reg  <= a_nx;
            acc    <= acc_nx;
            cnt    <= cnt_nx;
            result <= result_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        a_nx      = a_reg;
        acc_nx    = acc;
        cnt_nx    = cnt;
        result_nx = result;
        case (state)
            IDLE: begin
                if (start) begin
                    a_nx     = operand;
                    acc_nx   = operand;
                    cnt_nx   = CW'(N - 2);
                    state_nx = SQR;
                end
            end
            SQR: begin
                acc_nx = prod;
                if (cnt != '0) begin
                    state_nx = MUL;
                end else begin
                    result_nx = prod;
                    state_nx  = DONE;
                end
            end
            MUL: begin
                acc_nx   = prod;
                cnt_nx   = cnt - 1'b1;
                state_nx = SQR;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ff_inverse.sv
// Scoreboard bench for ff_inverse: queued expectations from a
// brute-force GF(2^8) inverse model, checked by a done-driven monitor.
module tb_ff_inverse;

    logic       clk;
    logic       n_rst;
    logic       start;
    logic [7:0] operand;
    logic       busy;
    logic       done;
    logic [7:0] result;

    ff_inverse #(
        .NUM_BITS(8),
        .POLY    (9'h11B)
    ) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .start  (start),
        .operand(operand),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    typedef struct {
        logic [7:0] op;
        logic [7:0] exp;
        int         cyc;
    } item_t;

    item_t q[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    ndone = 0;
    int    npush = 0;
    logic [7:0] prev_res;
    logic       prev_ok = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shift-and-add multiply in AES field, xtime reduction per step.
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        int r, x;
        r = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (((b >> i) & 1) != 0) r = r ^ x;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11B;
        end
        return r[7:0];
    endfunction

    function automatic logic [7:0] m_inv(input logic [7:0] a);
        if (a == 0) return 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (m_mul(a, y[7:0]) == 8'h01) return y[7:0];
        end
        return 8'h00;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            if (done) begin
                item_t it;
                ndone++;
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL done_busy: busy=%b want 1", busy);
                end
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done: result=%h want no pulse", result);
                end else begin
                    it = q.pop_front();
                    if (result !== it.exp) begin
                        bad++;
                        $display("FAIL result op=%h: got %h want %h", it.op, result, it.exp);
                    end
                    total++;
                    if (cyc - it.cyc != 14) begin
                        bad++;
                        $display("FAIL latency op=%h: got %0d want 14", it.op, cyc - it.cyc);
                    end
                    if (it.op != 0) begin
                        total++;
                        if (m_mul(it.op, result) !== 8'h01) begin
                            bad++;
                            $display("FAIL product op=%h: got %h want 01", it.op, m_mul(it.op, result));
                        end
                    end
                end
            end else if (prev_ok) begin
                total++;
                if (result !== prev_res) begin
                    bad++;
                    $display("FAIL result_stable: got %h want %h", result, prev_res);
                end
            end
            prev_res = result;
            prev_ok  = 1'b1;
        end else begin
            prev_ok = 1'b0;
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy === 1'b1; i++) @(negedge clk);
        if (busy !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL timeout: busy=%b want 0", busy);
        end
    endtask

    task automatic issue(input logic [7:0] op, input logic [7:0] exp);
        wait_idle();
        start   = 1'b1;
        operand = op;
        q.push_back('{op: op, exp: exp, cyc: cyc});
        npush++;
        @(negedge clk);
        start   = 1'b0;
        operand = 8'($urandom);
    endtask

    initial begin
        logic [7:0] r;
        n_rst   = 1'b0;
        start   = 1'b0;
        operand = 8'h00;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_busy", {7'd0, busy}, 8'h00);
            chk("rst_done", {7'd0, done}, 8'h00);
            chk("rst_result", result, 8'h00);
        end

        issue(8'h53, 8'hCA);
        issue(8'hCA, 8'h53);
        issue(8'h01, 8'h01);
        issue(8'h02, 8'h8D);
        issue(8'h00, 8'h00);
        issue(8'hFF, 8'h1C);

        for (int i = 0; i < 256; i++) issue(i[7:0], m_inv(i[7:0]));
        for (int i = 0; i < 40; i++) begin
            r = 8'($urandom);
            issue(r, m_inv(r));
        end

        wait_idle();
        start   = 1'b1;
        operand = 8'h53;
        q.push_back('{op: 8'h53, exp: 8'hCA, cyc: cyc});
        npush++;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            start   = (k == 3 || k == 13);
            operand = (k == 3 || k == 13) ? 8'h02 : 8'($urandom);
        end
        start = 1'b0;

        wait_idle();
        start   = 1'b1;
        operand = 8'h53;
        q.push_back('{op: 8'h53, exp: 8'hCA, cyc: cyc});
        npush++;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk("abort_busy", {7'd0, busy}, 8'h00);
        chk("abort_done", {7'd0, done}, 8'h00);
        chk("abort_result", result, 8'h00);
        npush = npush - q.size();
        q.delete();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        issue(8'h02, 8'h8D);

        wait_idle();
        repeat (2) @(negedge clk);
        total++;
        if (ndone != npush) begin
            bad++;
            $display("FAIL done_count: got %0d want %0d", ndone, npush);
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL pending: got %0d want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
